dmem_pipelined: RTL
===================

DMEM_PIPELINED -- requirements
Module: dmem_pipelined

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of words; power of two, at least 2.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to response availability; legal range 1..4.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 reqValid  in  1  request present.
REQ-007 reqReady  out  1  request can be accepted.
REQ-008 reqWrite  in  1  1 = store, 0 = load.
REQ-009 reqAddress  in  32  byte address; word index = address / (DATA_WIDTH/8).
REQ-010 reqData  in  DATA_WIDTH  store data.
REQ-011 reqByteEnable  in  DATA_WIDTH/8  per-byte store mask; ignored for loads.
REQ-012 rspValid  out  1  response present.
REQ-013 rspReady  in  1  consumer accepts the response.
REQ-014 rspData  out  DATA_WIDTH  load data; 0 for stores and errors.
REQ-015 rspWrite  out  1  echoes reqWrite of the originating request.
REQ-016 rspError  out  1  request was rejected by the bounds check.

Function
REQ-017 A request is accepted in any cycle where reqValid and reqReady are both 1.
REQ-018 reqReady is driven only from registered state, with no combinational path from rspReady.
REQ-019 An accepted store writes only its enabled bytes, in the acceptance cycle.
REQ-020 An accepted load reads the array in the acceptance cycle. A load in the cycle after a store to the same word returns the stored value.
REQ-021 Every accepted request, load or store, produces exactly one response, in acceptance order.
REQ-022 A response becomes visible exactly LATENCY cycles after acceptance when the response queue is empty.
REQ-023 A response leaves the queue when rspValid and rspReady are both 1.
REQ-024 Accepted requests travel through a LATENCY-stage valid/data shift pipeline into a response FIFO of depth LATENCY+1.
REQ-025 The outstanding counter counts accepted requests not yet popped: +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
REQ-026 reqReady = 1 when outstanding < LATENCY+1. With rspReady held at 1, throughput is one request per cycle.
REQ-027 If rspReady is held low, accepted requests never overflow and are never dropped. rspValid, rspData, rspWrite and rspError hold stable while rspValid is 1 and rspReady is 0.

Reset
REQ-028 While reset is 0, the block holds reqReady = 0, rspValid = 0, rspData = 0, rspWrite = 0, rspError = 0, outstanding = 0, the FIFO empty and the pipeline valids cleared.
REQ-029 Asserting reset mid-operation discards in-flight and queued responses. Array contents are preserved.
REQ-030 The array initialises to all zeros at time zero, not on reset.
REQ-031 reqReady rises in the first cycle after reset deasserts.

Configuration
REQ-032 Macro DMEM_BOUNDS_CHECK_EN is defined: an address with word index ≥ DEPTH_WORDS, or with nonzero sub-word offset bits, performs no write. It returns rspError = 1 and rspData = 0 at normal latency.
REQ-033 Macro DMEM_BOUNDS_CHECK_EN is undefined: the word index wraps modulo DEPTH_WORDS, offset bits are ignored, and rspError is tied to 0.

Structure
REQ-034 Package dmem_pkg holds the response struct typedef (data, write, error), the LATENCY bounds, and the legal DATA_WIDTH values. The block checks these bounds with elaboration-time assertions.
REQ-035 The response FIFO is the sub-module dmem_rsp_fifo, parametrised by width and depth, and provides full, empty and count outputs.

Verification
REQ-036 Reset release with LATENCY=2: store 0xDEADBEEF to 0x10 with byteEnable 0xF, then load 0x10 next cycle → two in-order responses at cycle +2 and +3; the load returns 0xDEADBEEF with rspError = 0.
REQ-037 Partial store: word 0x20 holds 0x11223344, then store 0xAABBCCDD with byteEnable 0x5 → subsequent load returns 0x11BB33DD.
REQ-038 Backpressure: rspReady = 0, issue 10 loads → exactly 3 accepted (LATENCY+1), reqReady low. Raise rspReady → responses drain in order and reqReady recovers with no loss.
REQ-039 Streaming: 100 back-to-back loads with rspReady = 1 → reqReady never drops and each response arrives exactly 2 cycles after its request.
REQ-040 Bounds check with macro defined and DEPTH_WORDS = 1024: store to 0x1000 → rspError = 1 and memory is unchanged. Without the macro, the same store writes word 0.
REQ-041 Reset asserted with 2 responses queued → rspValid = 0 immediately. After release, a load from a previously written address returns the stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and legal parameter bounds for the pipelined data memory.
package dmem_pkg;

  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 4;
  localparam int DW_NARROW = 32;
  localparam int DW_WIDE   = 64;
  localparam int DW_MAX    = DW_WIDE;

  // Data is sized for the widest legal word; narrow builds zero-extend.
  typedef struct packed {
    logic [DW_MAX-1:0] data;
    logic              write;
    logic              error;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Response queue for dmem_pipelined: circular buffer, head read combinationally
// and forced to zero while empty so idle outputs stay quiet.
module dmem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined byte-maskable data memory with fixed-latency in-order responses.
// Optional DMEM_BOUNDS_CHECK_EN rejects out-of-range / misaligned addresses.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [31:0]             reqAddress,
  input  logic [DATA_WIDTH-1:0]   reqData,
  input  logic [DATA_WIDTH/8-1:0] reqByteEnable,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [DATA_WIDTH-1:0]   rspData,
  output logic                    rspWrite,
  output logic                    rspError
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int OFS_W      = $clog2(BYTES);
  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int FIFO_DEPTH = LATENCY + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int STAGES     = LATENCY - 1;
  localparam int RSP_W      = $bits(dmem_rsp_t);

  if (DATA_WIDTH != DW_NARROW && DATA_WIDTH != DW_WIDE) begin : g_bad_dw
    $error("dmem_pipelined: DATA_WIDTH must be 32 or 64");
  end
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
    $error("dmem_pipelined: LATENCY out of range 1..4");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_pipelined: DEPTH_WORDS must be a power of two >= 2");
  end
  if (IDX_W + OFS_W >= 32) begin : g_bad_span
    $error("dmem_pipelined: memory span must fit below a 32-bit address");
  end

  logic                  run_q;
  logic [CNT_W-1:0]      outstanding_q;
  logic                  accept, pop;
  logic [IDX_W-1:0]      widx;
  logic                  addr_err;
  dmem_rsp_t             stg0, push_rsp, head;
  logic                  push_vld;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_ok;

  // Contents survive reset; only time-zero initialisation clears them.
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

  // Ready depends only on registers, so no path from rspReady reaches it.
  assign reqReady = run_q && (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign accept   = reqValid && reqReady;
  assign pop      = rspValid && rspReady;
  assign widx     = reqAddress[OFS_W +: IDX_W];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_err  = ((reqAddress >> OFS_W) >= 32'(DEPTH_WORDS)) ||
                     (reqAddress[OFS_W-1:0] != '0);
  assign unused_ok = ^{fifo_full, fifo_count, head.data};
`else
  // Index wraps: bits above the array span and sub-word offset are dropped.
  assign addr_err  = 1'b0;
  assign unused_ok = ^{fifo_full, fifo_count, head.data,
                       reqAddress[31:OFS_W+IDX_W], reqAddress[OFS_W-1:0]};
`endif

  always_comb begin
    stg0       = '0;
    stg0.write = reqWrite;
    stg0.error = addr_err;
    if (!reqWrite && !addr_err) stg0.data = DW_MAX'(mem[widx]);
  end

  always_ff @(posedge clock) begin
    if (accept && reqWrite && !addr_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (reqByteEnable[b]) mem[widx][b*8 +: 8] <= reqData[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      run_q <= 1'b1;
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // The FIFO write is the final stage, so LATENCY-1 register stages precede it.
  if (LATENCY == 1) begin : g_lat1
    assign push_vld = accept;
    assign push_rsp = stg0;
  end else begin : g_pipe
    logic [STAGES:1] vld_pipe;
    dmem_rsp_t       stg_q [1:STAGES];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        vld_pipe <= '0;
        for (int s = 1; s <= STAGES; s++) stg_q[s] <= '0;
      end else begin
        vld_pipe[1] <= accept;
        stg_q[1]    <= stg0;
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          stg_q[s]    <= stg_q[s-1];
        end
      end
    end

    assign push_vld = vld_pipe[STAGES];
    assign push_rsp = stg_q[STAGES];
  end

  dmem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_vld),
    .din   (push_rsp),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rspValid = !fifo_empty;
  assign rspData  = head.data[DATA_WIDTH-1:0];
  assign rspWrite = head.write;
  assign rspError = head.error;

endmodule
